wb_host_bridge: RTL and testbench

WB_HOST_BRIDGE -- requirements
Module: wb_host_bridge

---
 rtl/wb_host_bridge_if.sv | 49 ++++
 rtl/wb_host_bridge.sv | 152 +++++++++++++++
 tb/tb_wb_host_bridge.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_host_bridge_if.sv
// wb_host_bridge_if: groups the bridge's command, response and Wishbone initiator signals.
//   master modport : the bridge side (takes commands, returns responses, drives Wishbone)
//   slave modport  : the environment side (issues commands, consumes responses, is the
//                    Wishbone target)
// Signals:
//   cmd_valid/cmd_ready/cmd_we/cmd_adr/cmd_dat/cmd_sel : command request channel
//   rsp_valid/rsp_ready/rsp_dat/rsp_err                 : response channel
//   wbm_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o              : Wishbone initiator outputs
//   wbm_ack_i/wbm_dat_i                                 : Wishbone initiator inputs
interface wb_host_bridge_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    input  rsp_ready,
    input  wbm_ack_i, wbm_dat_i,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel,
    output rsp_ready,
    output wbm_ack_i, wbm_dat_i,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/wb_host_bridge.sv
// wb_host_bridge: command/response to Wishbone classic single-access initiator.
// One transaction outstanding at a time: IDLE accepts a command, BUS runs the Wishbone
// cycle until ack or timeout, RESP holds the response until it is consumed.
// Ports:
//   wb_clk_i : clock, all state on the rising edge
//   wb_rst_i : asynchronous active-high reset
//   bus      : wb_host_bridge_if.master (command, response and Wishbone signals)
//   err_cnt  : saturating count of timed-out cycles
// Parameters:
//   TIMEOUT  : cycles a bus cycle may stay open without ack (2..65535)
//   ERR_DATA : read data returned on a timeout
module wb_host_bridge #(
  parameter int unsigned TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_host_bridge_if.master bus,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } state_e;

  // Counter value at the edge that closes the TIMEOUT-th cycle without ack.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      tcnt_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      tcnt_q      <= tcnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    tcnt_d      = tcnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      StIdle: begin
        // cmd_ready_q is only high in IDLE; it also masks the first cycle after reset.
        if (bus.cmd_valid && cmd_ready_q) begin
          state_d = StBus;
          cyc_d   = 1'b1;
          we_d    = bus.cmd_we;
          sel_d   = bus.cmd_sel;
          adr_d   = bus.cmd_adr;
          dat_d   = bus.cmd_dat;
          tcnt_d  = '0;
        end
      end
      StBus: begin
        // Ack wins over a timeout landing on the same edge.
        if (bus.wbm_ack_i) begin
          state_d     = StResp;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = we_q ? 32'h0 : bus.wbm_dat_i;
        end else if (tcnt_q == TimeoutLast) begin
          state_d     = StResp;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = we_q ? 32'h0 : ERR_DATA;
          if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    cmd_ready_d = (state_d == StIdle);
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.rsp_err   = rsp_err_q;

  // Attribute outputs are forced to zero whenever no cycle is open.
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.wbm_we_o  = cyc_q & we_q;
  assign bus.wbm_sel_o = cyc_q ? sel_q : 4'h0;
  assign bus.wbm_adr_o = cyc_q ? adr_q : 32'h0;
  assign bus.wbm_dat_o = cyc_q ? dat_q : 32'h0;

  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_wb_host_bridge.sv
// Self-checking bench for wb_host_bridge (TIMEOUT=8): directed cases, randomized
// transactions, reset mid-cycle and err_cnt saturation, all against a transaction-level model.
module tb_wb_host_bridge;
  localparam int unsigned TO   = 8;
  localparam logic [31:0] ERRD = 32'hFFFF_FFFF;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_err_cnt = 0;

  wb_host_bridge_if bus ();

  wb_host_bridge #(
    .TIMEOUT (TO),
    .ERR_DATA(ERRD)
  ) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle_wb();
    check_eq("idle_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    check_eq("idle_stb", 32'(bus.wbm_stb_o), 32'd0);
    check_eq("idle_we", 32'(bus.wbm_we_o), 32'd0);
    check_eq("idle_sel", 32'(bus.wbm_sel_o), 32'd0);
    check_eq("idle_adr", bus.wbm_adr_o, 32'd0);
    check_eq("idle_dat", bus.wbm_dat_o, 32'd0);
  endtask

  // Wait (bounded) for cmd_ready at a falling edge, then present a command.
  task automatic issue_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    int w;
    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 20) begin
      @(negedge wb_clk_i);
      w++;
    end
    check_eq("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_dat   = dat;
    bus.cmd_sel   = sel;
    @(negedge wb_clk_i);
    // Scramble the held fields: the bridge must have captured them already.
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'($urandom);
    bus.cmd_adr   = $urandom;
    bus.cmd_dat   = $urandom;
    bus.cmd_sel   = 4'($urandom);
    check_eq("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
  endtask

  // One full transaction. ack_at = BUS cycle (1-based) on which the target acks, 0 = never.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int ack_at, input int rsp_wait,
                         input bit inject);
    logic [31:0] sdat;
    logic [31:0] exp_dat;
    bit          tmo;
    int          exp_n;
    int          n;
    sdat    = $urandom;
    tmo     = !(ack_at >= 1 && ack_at <= int'(TO));
    exp_n   = tmo ? int'(TO) : ack_at;
    exp_dat = we ? 32'h0 : (tmo ? ERRD : sdat);

    issue_cmd(we, adr, dat, sel);
    n = 0;
    while (bus.wbm_cyc_o === 1'b1 && n < 40) begin
      n++;
      check_eq("bus_stb", 32'(bus.wbm_stb_o), 32'd1);
      check_eq("bus_we", 32'(bus.wbm_we_o), 32'(we));
      check_eq("bus_adr", bus.wbm_adr_o, adr);
      check_eq("bus_dat", bus.wbm_dat_o, dat);
      check_eq("bus_sel", 32'(bus.wbm_sel_o), 32'(sel));
      bus.wbm_ack_i = (n == ack_at);
      bus.wbm_dat_i = (n == ack_at) ? sdat : $urandom;
      @(negedge wb_clk_i);
    end
    bus.wbm_ack_i = 1'b0;
    check_eq("cyc_cycles", 32'(n), 32'(exp_n));
    if (tmo && exp_err_cnt < 255) exp_err_cnt++;

    check_eq("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check_eq("rsp_dat", bus.rsp_dat, exp_dat);
    check_eq("rsp_err", 32'(bus.rsp_err), 32'(tmo));
    check_eq("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
    check_idle_wb();

    for (int i = 0; i < rsp_wait; i++) begin
      // A stray ack while holding the response must be ignored.
      bus.wbm_ack_i = inject && (i == 0);
      bus.wbm_dat_i = $urandom;
      @(negedge wb_clk_i);
      bus.wbm_ack_i = 1'b0;
      check_eq("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("hold_dat", bus.rsp_dat, exp_dat);
      check_eq("hold_err", 32'(bus.rsp_err), 32'(tmo));
      check_eq("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check_eq("hold_cyc", 32'(bus.wbm_cyc_o), 32'd0);
      check_eq("hold_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
    end

    bus.rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    bus.rsp_ready = 1'b0;
    check_eq("done_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("done_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    if (inject) begin
      // Stray ack in IDLE: nothing may move.
      bus.wbm_ack_i = 1'b1;
      bus.wbm_dat_i = $urandom;
      @(negedge wb_clk_i);
      bus.wbm_ack_i = 1'b0;
      check_eq("idle_ack_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("idle_ack_ready", 32'(bus.cmd_ready), 32'd1);
      check_eq("idle_ack_errcnt", 32'(err_cnt), 32'(exp_err_cnt));
      check_idle_wb();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = '0;
    bus.cmd_dat   = '0;
    bus.cmd_sel   = '0;
    bus.rsp_ready = 1'b0;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = '0;

    // Reset state.
    repeat (2) @(negedge wb_clk_i);
    check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_dat", bus.rsp_dat, 32'd0);
    check_eq("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
    check_idle_wb();
    wb_rst_i = 1'b0;
    #1;
    check_eq("rel_cmd_ready_pre", 32'(bus.cmd_ready), 32'd0);
    @(negedge wb_clk_i);
    check_eq("rel_cmd_ready_post", 32'(bus.cmd_ready), 32'd1);

    // Directed: write with ack on the 3rd cyc cycle, read acked on the 1st.
    run_txn(1'b1, 32'h3000_0010, 32'hA5A5_0001, 4'hF, 3, 0, 1'b0);
    run_txn(1'b0, 32'h3800_0000, 32'h0, 4'hF, 1, 0, 1'b0);
    // Timeout read, then ack on the timeout cycle.
    run_txn(1'b0, 32'h3800_0004, 32'h0, 4'hF, 0, 0, 1'b0);
    run_txn(1'b0, 32'h3800_0008, 32'h0, 4'h3, int'(TO), 0, 1'b0);
    // Backpressure with an injected ack.
    run_txn(1'b0, 32'h1000_0000, 32'hDEAD_BEEF, 4'h5, 2, 5, 1'b1);
    // Timed-out write returns zero data.
    run_txn(1'b1, 32'h2000_0000, 32'h0BAD_F00D, 4'hC, 0, 1, 1'b0);

    // Reset in the middle of a bus cycle.
    issue_cmd(1'b0, 32'h4000_0000, 32'h1111_2222, 4'hF);
    repeat (2) @(negedge wb_clk_i);
    check_eq("mid_cyc", 32'(bus.wbm_cyc_o), 32'd1);
    #2 wb_rst_i = 1'b1;
    #1;
    check_eq("mid_rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    check_eq("mid_rst_stb", 32'(bus.wbm_stb_o), 32'd0);
    check_eq("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("mid_rst_errcnt", 32'(err_cnt), 32'd0);
    exp_err_cnt = 0;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check_eq("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check_idle_wb();

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 10)),
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Saturation of the timeout counter.
    for (int k = 0; k < 300; k++) begin
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), 0, 0, 1'b0);
    end
    check_eq("err_cnt_sat", 32'(err_cnt), 32'd255);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
